// File: rtl/add_pipe_pkg.sv
// Shared constants and mode encoding for the add_pipe adder/subtractor pipeline.
package add_pipe_pkg;

   localparam int ADD_PIPE_MAX_STAGES = 8;
   localparam int ADD_PIPE_CNT_W      = 16;

   typedef enum logic {
      ADD_MODE = 1'b0,
      SUB_MODE = 1'b1
   } add_mode_e;

endpackage

// File: rtl/add_pipe_slice.sv
// One valid/data register slice of the add_pipe pipeline.
module add_pipe_slice #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         drain,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   // A load wins over a drain: the slice hands its beat on and refills in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/add_pipe.sv
// Elastic STAGES-deep add/subtract pipeline with collapsing bubbles.
// Optional completed-result counter txn_count under `define ADD_PIPE_STATS_EN.
module add_pipe
   import add_pipe_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          a,
   input  logic [WIDTH-1:0]          b,
   input  logic                      sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH:0]            sum
`ifdef ADD_PIPE_STATS_EN
   ,
   output logic [ADD_PIPE_CNT_W-1:0] txn_count
`endif
);

   // Handshake: a beat moves on a cycle where valid && ready are both high at the
   // clock edge; valid never waits on ready, and ready is independent of valid.

   logic [STAGES-1:0] valid;
   logic [STAGES-1:0] advance;
   logic [WIDTH:0]    data [STAGES];

   // Walk from the output back toward the input: a slice may move when the slice
   // after it is empty or moving itself, which lets bubbles collapse.
   always_comb begin
      logic ok;
      advance = '0;
      ok      = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         advance[i] = valid[i] && ok;
         ok         = !valid[i] || advance[i];
      end
      in_ready = ok;
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_slice
      logic           load;
      logic [WIDTH:0] d;

      if (i == 0) begin : g_first
         assign load = in_valid && in_ready;
         assign d    = (add_mode_e'(sub) == SUB_MODE) ? ({1'b0, a} - {1'b0, b})
                                                      : ({1'b0, a} + {1'b0, b});
      end else begin : g_carry
         assign load = advance[i-1];
         assign d    = data[i-1];
      end

      add_pipe_slice #(
         .W(WIDTH + 1)
      ) u_slice (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .drain(advance[i]),
         .d    (d),
         .valid(valid[i]),
         .q    (data[i])
      );
   end

   assign out_valid = valid[STAGES-1];
   assign sum       = data[STAGES-1];

`ifdef ADD_PIPE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         txn_count <= '0;
      end else if (out_valid && out_ready) begin
         txn_count <= txn_count + ADD_PIPE_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=4, STAGES=2); wrap test under ADD_PIPE_STATS_EN.
module tb_add_pipe;

   localparam int WIDTH  = 4;
   localparam int STAGES = 2;
   localparam int SW     = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [SW-1:0]    sum;
`ifdef ADD_PIPE_STATS_EN
   logic [15:0]      txn_count;
`endif

   int            checks   = 0;
   int            failures = 0;
   logic [SW-1:0] exp_q[$];
   int            run_len  = 0;
   int            run_max  = 0;
   int            model_txn = 0;
   logic          hold_flag = 1'b0;
   logic [SW-1:0] held;

   add_pipe #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum)
`ifdef ADD_PIPE_STATS_EN
      ,
      .txn_count(txn_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: exact sum, or difference modulo 2^(WIDTH+1).
   function automatic logic [SW-1:0] model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                           input logic sv);
      int r;
      if (sv) r = (int'(av) - int'(bv) + (1 << SW)) % (1 << SW);
      else    r = int'(av) + int'(bv);
      return r[SW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   // driver: offer one beat, push its expected result when accepted
   task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv,
                       output int waits);
      bit done = 0;
      waits = 0;
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(av, bv, sv));
            done = 1;
         end else if (++waits > 50) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
            done = 1;
         end
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_rand(output int waits);
      send(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           waits);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         hold_flag = 1'b0;
         run_len   = 0;
      end else begin
         if (hold_flag) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sum", 32'(sum), 32'(held));
         end
         hold_flag = out_valid && !out_ready;
         held      = sum;
         if (out_valid) run_len++;
         else run_len = 0;
         if (run_len > run_max) run_max = run_len;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_out actual=%0h required=no_output", sum);
            end else begin
               check("sum", 32'(sum), 32'(exp_q.pop_front()));
            end
            model_txn = (model_txn + 1) % 65536;
         end
      end
   end

   initial begin
      int w;
      int n;
      logic [SW-1:0] s;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      wait_cycles(2);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_in_ready", 32'(in_ready), 1);
`ifdef ADD_PIPE_STATS_EN
      check("rst_txn", 32'(txn_count), 0);
`endif
      tick();
      rst = 1'b0;
      check("in_ready_after_rst", 32'(in_ready), 1);

      // 15+15 with latency
      send(4'd15, 4'd15, 1'b0, w);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      check("latency", n, STAGES);
      check("sum_15_15", 32'(sum), 30);
      wait_cycles(3);

      // 3-5 borrow
      send(4'd3, 4'd5, 1'b1, w);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 10);
      check("borrow_sum", 32'(sum), 32'(5'b11110));
      wait_cycles(3);

      // back-to-back 4 beats
      run_max = 0;
      for (int i = 0; i < 4; i++) begin
         send_rand(w);
         check("b2b_wait", w, 0);
      end
      wait_cycles(6);
      check("b2b_run", run_max, 4);

      // stalled output fills the pipe, then simultaneous in/out handshake
      out_ready = 1'b0;
      send_rand(w);
      send_rand(w);
      a = 4'd9; b = 4'd2; sub = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 0);
      check("full_out_valid", 32'(out_valid), 1);
      s = sum;
      tick();
      @(negedge clk);
      check("stall_sum", 32'(sum), 32'(s));
      check("stall_in_ready", 32'(in_ready), 0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("same_cycle_in_ready", 32'(in_ready), 1);
      check("same_cycle_out_valid", 32'(out_valid), 1);
      if (in_ready) exp_q.push_back(model(4'd9, 4'd2, 1'b1));
      tick();
      in_valid = 1'b0;
      wait_cycles(6);
      check("drain_empty", exp_q.size(), 0);

      // reset with beats in flight
      send_rand(w);
      send_rand(w);
      #1;
      rst = 1'b1;
      exp_q.delete();
      model_txn = 0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_sum", 32'(sum), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
`ifdef ADD_PIPE_STATS_EN
      check("midrst_txn", 32'(txn_count), 0);
`endif
      wait_cycles(2);
      rst = 1'b0;
      check("postrst_in_ready", 32'(in_ready), 1);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      check("no_stale", n, 0);
      tick();

      // randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         a   = WIDTH'($urandom_range(0, 15));
         b   = WIDTH'($urandom_range(0, 15));
         sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      check("random_drain", exp_q.size(), 0);
      wait_cycles(2);
`ifdef ADD_PIPE_STATS_EN
      check("txn_model", 32'(txn_count), 32'(model_txn));

      // preload 0xFFFF then wrap
      rst = 1'b1;
      exp_q.delete();
      model_txn = 0;
      wait_cycles(2);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 70000 && n < 65535; i++) begin
         a   = WIDTH'($urandom_range(0, 15));
         b   = WIDTH'($urandom_range(0, 15));
         sub = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(a, b, sub));
            n++;
         end
         tick();
      end
      in_valid = 1'b0;
      wait_cycles(4);
      check("txn_ffff", 32'(txn_count), 32'hFFFF);
      send_rand(w);
      wait_cycles(4);
      check("txn_wrap", 32'(txn_count), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
